fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the byte-addressed, big-endian instruction memory. Owns the program counter and drives the memory's 32-bit read address. Registers the returned word into an IF/ID holding register with a valid/ready handshake toward decode. Handles branch/jump redirects, downstream stalls, halt and misaligned-target detection.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `MEM_BYTES`, default 256: instruction memory size in bytes; power of two, at least 4.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins fetching from IDLE.
- `halt` in 1: stops fetching; level-sensitive, sampled each edge.
- `mem_addr` out 32: read address to the instruction memory; equals `pc`.
- `mem_data` in 32: instruction word from memory, combinational from `mem_addr`.
- `redirect` in 1: taken branch/jump this cycle.
- `redirect_target` in 32: new PC when `redirect`=1.
- `inst_out` out 32: registered instruction.
- `pc_out` out 32: address `inst_out` was fetched from.
- `inst_valid` out 1: `inst_out`/`pc_out` hold an unconsumed instruction.
- `inst_ready` in 1: decode accepts when `inst_valid && inst_ready`.
- `misalign_err` out 1: sticky; set on a redirect target with bits [1:0]≠0.
- `fsm_state` out 2: current state (IDLE=0, RUN=1, HALT=2).

## Operation
- States: IDLE, RUN, HALT (terminal until reset).
  - IDLE→RUN on `start`.
  - RUN→HALT on `halt`, or on a misaligned redirect.
  - `start` is ignored outside IDLE; `halt` in IDLE goes to HALT.
- Internal `pc` is 32 bits. Every PC update is reduced modulo MEM_BYTES (upper bits forced 0), so `mem_addr` never leaves the memory.
- `mem_addr` = `pc` at all times; memory read is combinational.
- Edge priority in RUN, highest first:
  1. `halt`: no fetch; PC holds; `inst_valid`/`inst_out` keep their value until accepted, then `inst_valid`←0.
  2. `redirect` with misaligned target: `misalign_err`←1, `inst_valid`←0, state←HALT, PC unchanged.
  3. `redirect` with aligned target: `pc`←`target mod MEM_BYTES`, `inst_valid`←0. Any unaccepted instruction is discarded, even if `inst_ready`=1 the same cycle.
  4. Advance, when `!inst_valid || inst_ready`:
     - `inst_out`←`mem_data`, `pc_out`←`pc`, `inst_valid`←1.
     - `pc`←(`pc`+4) mod MEM_BYTES; `MEM_BYTES-4` wraps to 0.
  5. Otherwise stall: all registers hold.
- In IDLE and HALT: no fetch; PC holds.
- Reset (asynchronous, any time including mid-redirect or stall):
  - `pc`=RESET_PC, state=IDLE.
  - `inst_valid`=0, `inst_out`=0, `pc_out`=0, `misalign_err`=0.
  - `mem_addr`=RESET_PC.

## Timing
- Fetch latency: the word at `pc` is visible on `inst_out` one edge after `pc` is presented.
- Throughput: one instruction per cycle while `inst_ready`=1.
- `start` sampled at edge E → state=RUN after E. First fetch at E+1, so `inst_valid`=1 after E+1 with `pc_out`=RESET_PC.
- Redirect sampled at edge E → bubble cycle after E. Target instruction is valid after E+1.
- Handshake:
  - `inst_out`/`pc_out` stay stable while `inst_valid && !inst_ready`.
  - `inst_valid` never deasserts without acceptance, except on redirect, misalignment or reset.
- `misalign_err` rises at the edge sampling the bad redirect and stays high until reset.

## Structure
- Shared package `fetch_pkg`:
  - state encoding constants FS_IDLE/FS_RUN/FS_HALT;
  - INST_BYTES=4;
  - alignment-mask constant.
- One sub-module is natural: `pc_next_logic`. It is combinational and takes pc, redirect, target, advance and MEM_BYTES. It produces next_pc (wrapped) and a misalign flag.
- The FSM and handshake registers stay in `fetch_controller`.

## Test plan
- Reset, then `start` with memory holding 0x20080005 at byte 0 and 0x20090003 at byte 4, `inst_ready`=1 → `inst_out`=0x20080005/`pc_out`=0 after edge 2, then 0x20090003/4 after edge 3.
- Hold `inst_ready`=0 for 3 cycles after the first valid instruction → `inst_out`, `pc_out`, `mem_addr`=4 stable. Release → next instruction `pc_out`=4, no skip or duplicate.
- Redirect to 0x40 while the instruction at 8 is unaccepted → one bubble, discarded word never accepted, next `pc_out`=0x40.
- Run sequentially to `pc`=0xFC with MEM_BYTES=256 → instruction `pc_out`=0xFC, then `pc_out`=0x00. Redirect to 0x104 → `pc_out`=0x04.
- Redirect to 0x42 → `misalign_err`=1, `fsm_state`=HALT, `inst_valid`=0. Later `start`/`redirect` are ignored; `rst_n` low clears everything.
- Assert `halt` with `inst_valid`=1, `inst_ready`=0. Then raise `inst_ready` → one acceptance, then `inst_valid`=0, no further fetch. Assert `rst_n`=0 asynchronously mid-cycle → outputs reach reset values before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// instruction width and the word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetchStateT;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK = 32'(INST_BYTES - 1);

  function automatic logic isAligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory read port plus the IF/ID valid/ready handshake toward decode.
interface fetch_controller_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output mem_addr, inst_out, pc_out, inst_valid,
    input  mem_data, inst_ready
  );

  modport slave (
    input  mem_addr, inst_out, pc_out, inst_valid,
    output mem_data, inst_ready
  );

endinterface

// File: rtl/fetch_controller_pc_next_logic.sv
// Combinational next-PC selection: aligned redirect, sequential advance or hold,
// always wrapped into the instruction memory's address range.
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] next_pc,
  output logic        misalign
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_pc  = pc;
    misalign = redirect && !isAligned(target);
    if (redirect) begin
      if (!misalign) next_pc = target & ADDR_MASK;
    end else if (advance) begin
      next_pc = (pc + 32'(INST_BYTES)) & ADDR_MASK;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words into the
// IF/ID holding register and handles redirects, stalls, halt and bad targets.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      redirect,
  input  logic [31:0]               redirect_target,
  output logic                      misalign_err,
  output logic [1:0]                fsm_state,
  fetch_controller_if.master        fif
);

  fetchStateT  state;
  logic [31:0] pc;
  logic [31:0] nextPc;
  logic        misalign;
  logic        active;
  logic        redirectEn;
  logic        advance;
  logic        accepted;

  // Redirects and fetches only matter while running and not halting.
  assign active     = (state == FS_RUN) && !halt;
  assign redirectEn = active && redirect;
  assign advance    = active && (!fif.inst_valid || fif.inst_ready);
  assign accepted   = fif.inst_valid && fif.inst_ready;

  assign fif.mem_addr = pc;
  assign fsm_state    = state;

  pc_next_logic #(
    .MEM_BYTES(MEM_BYTES)
  ) u_pc_next (
    .pc       (pc),
    .redirect (redirectEn),
    .target   (redirect_target),
    .advance  (advance),
    .next_pc  (nextPc),
    .misalign (misalign)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FS_IDLE;
      pc             <= RESET_PC;
      fif.inst_valid <= 1'b0;
      fif.inst_out   <= 32'd0;
      fif.pc_out     <= 32'd0;
      misalign_err   <= 1'b0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (halt)       state <= FS_HALT;
          else if (start) state <= FS_RUN;
        end
        FS_RUN: begin
          if (halt) begin
            state <= FS_HALT;
            if (accepted) fif.inst_valid <= 1'b0;
          end else if (misalign) begin
            misalign_err   <= 1'b1;
            fif.inst_valid <= 1'b0;
            state          <= FS_HALT;
          end else if (redirectEn) begin
            // A pending instruction is dropped even if decode takes it this cycle.
            pc             <= nextPc;
            fif.inst_valid <= 1'b0;
          end else if (advance) begin
            fif.inst_out   <= fif.mem_data;
            fif.pc_out     <= pc;
            fif.inst_valid <= 1'b1;
            pc             <= nextPc;
          end
        end
        FS_HALT: begin
          // Let decode drain the last held instruction; nothing new is fetched.
          if (accepted) fif.inst_valid <= 1'b0;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a word-array memory model and hand-computed
// expectations for start, stall, redirect, wrap, misalignment, halt and reset.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  fetch_controller_if fif ();

  fetch_controller #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .misalign_err   (misalign_err),
    .fsm_state      (fsm_state),
    .fif            (fif)
  );

  always #5 clk = ~clk;

  assign fif.mem_data = mem[fif.mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(fif.inst_valid), 32'd0);
    check({tag, "_inst"},  fif.inst_out,        32'd0);
    check({tag, "_pcout"}, fif.pc_out,          32'd0);
    check({tag, "_addr"},  fif.mem_addr,        32'd0);
    check({tag, "_state"}, 32'(fsm_state),      32'(FS_IDLE));
    check({tag, "_err"},   32'(misalign_err),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_target = 32'd0; fif.inst_ready = 1'b0;
    #12;
    check_reset("por");
    rst_n = 1'b1;

    // Start at edge 1, first instruction after edge 2.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; fif.inst_ready = 1'b1;
    check("start_state", 32'(fsm_state), 32'(FS_RUN));
    check("start_valid", 32'(fif.inst_valid), 32'd0);
    tick();
    check("first_inst",  fif.inst_out, 32'h2008_0005);
    check("first_pc",    fif.pc_out,   32'h0);
    check("first_valid", 32'(fif.inst_valid), 32'd1);

    // Decode stalls for three cycles: everything holds.
    fif.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_inst", fif.inst_out, 32'h2008_0005);
      check("stall_pc",   fif.pc_out,   32'h0);
      check("stall_addr", fif.mem_addr, 32'h4);
    end
    fif.inst_ready = 1'b1;
    tick();
    check("release_inst", fif.inst_out, 32'h2009_0003);
    check("release_pc",   fif.pc_out,   32'h4);
    tick();
    check("seq_pc8", fif.pc_out, 32'h8);

    // Redirect while the word at 8 is unaccepted.
    fif.inst_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h40;
    tick();
    redirect = 1'b0; fif.inst_ready = 1'b1;
    check("bubble_valid", 32'(fif.inst_valid), 32'd0);
    check("bubble_addr",  fif.mem_addr,        32'h40);
    tick();
    check("tgt_pc",   fif.pc_out,   32'h40);
    check("tgt_inst", fif.inst_out, 32'hA000_0040);

    // Walk sequentially up to the top of memory and wrap.
    for (int i = 0; i < 47; i++) tick();
    check("top_pc",   fif.pc_out,   32'hFC);
    check("top_inst", fif.inst_out, 32'hA000_00FC);
    tick();
    check("wrap_pc",   fif.pc_out,   32'h0);
    check("wrap_inst", fif.inst_out, 32'h2008_0005);

    // Out-of-range aligned target is reduced modulo memory size.
    redirect = 1'b1; redirect_target = 32'h104;
    tick();
    redirect = 1'b0;
    check("mod_addr", fif.mem_addr, 32'h4);
    tick();
    check("mod_pc",   fif.pc_out,   32'h4);
    check("mod_inst", fif.inst_out, 32'h2009_0003);

    // Misaligned redirect halts with a sticky error; later inputs ignored.
    redirect = 1'b1; redirect_target = 32'h42;
    tick();
    redirect = 1'b0;
    check("mis_err",   32'(misalign_err),   32'd1);
    check("mis_state", 32'(fsm_state),      32'(FS_HALT));
    check("mis_valid", 32'(fif.inst_valid), 32'd0);
    check("mis_addr",  fif.mem_addr,        32'h8);
    start = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    tick();
    start = 1'b0; redirect = 1'b0;
    check("ign_state", 32'(fsm_state),    32'(FS_HALT));
    check("ign_addr",  fif.mem_addr,      32'h8);
    check("ign_err",   32'(misalign_err), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("mis_rst");
    #1 rst_n = 1'b1;

    // Halt with a held instruction: one acceptance drains it, no further fetch.
    fif.inst_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("hv_valid", 32'(fif.inst_valid), 32'd1);
    halt = 1'b1;
    tick();
    check("h_state", 32'(fsm_state),      32'(FS_HALT));
    check("h_valid", 32'(fif.inst_valid), 32'd1);
    check("h_pc",    fif.pc_out,          32'h0);
    fif.inst_ready = 1'b1;
    tick();
    check("h_drain", 32'(fif.inst_valid), 32'd0);
    tick();
    check("h_nofetch_valid", 32'(fif.inst_valid), 32'd0);
    check("h_nofetch_addr",  fif.mem_addr,        32'h4);
    halt = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Halt in IDLE goes straight to HALT.
    halt = 1'b1; start = 1'b1;
    tick();
    halt = 1'b0; start = 1'b0;
    check("idle_halt", 32'(fsm_state), 32'(FS_HALT));
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Asynchronous reset mid-cycle while running with a valid word held.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("run_pc8", fif.pc_out, 32'h8);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    #1 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
